// File: rtl/counter_sched.sv
// Shared counter with two round-robin requesters issuing LOAD/COUNT commands.
// Three-state FSM (IDLE/EXEC/DONE); all outputs registered or decoded from state.
module counter_sched #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             pause,
  output logic [WIDTH-1:0] Q,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic             ptr;
  logic             op_l;
  logic [WIDTH-1:0] data_l;
  logic [WIDTH-1:0] steps;
  logic             win;
  logic             last;

  // Lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    win = (req0 && req1) ? ptr : req1;
  end

  always_comb begin
    last = (steps == '0) || (steps == WIDTH'(1));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Q      <= '0;
      grant  <= '0;
      ack    <= '0;
      wrap   <= 1'b0;
      steps  <= '0;
      ptr    <= 1'b0;
      op_l   <= 1'b0;
      data_l <= '0;
    end else begin
      ack  <= '0;
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant  <= win ? 2'b10 : 2'b01;
            ptr    <= ~win;
            op_l   <= win ? op1 : op0;
            data_l <= win ? data1 : data0;
            steps  <= win ? data1 : data0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (!op_l) begin
            Q     <= data_l;
            ack   <= grant;
            state <= DONE;
          end else if (!pause) begin
            if (steps != '0) begin
              Q     <= Q + WIDTH'(1);
              wrap  <= &Q;
              steps <= steps - WIDTH'(1);
            end
            if (last) begin
              ack   <= grant;
              state <= DONE;
            end
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: vector table, directed corner sequences,
// and random traffic checked against a transaction-level model.
module tb_counter_sched;

  localparam int W = 3;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic         op0 = 1'b0;
  logic         op1 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         pause = 1'b0;
  logic [W-1:0] Q;
  logic [1:0]   grant;
  logic [1:0]   ack;
  logic         busy;
  logic         wrap;

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
    .pause(pause),
    .Q(Q), .grant(grant), .ack(ack),
    .busy(busy), .wrap(wrap)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one command in flight, described by owner, kind and steps left.
  int mq, mgrant, mack, mwrap, mptr;
  bit m_busy, m_done, m_load;
  int m_val, m_left;

  task automatic model_step();
    int w;
    if (rst) begin
      mq = 0; mgrant = 0; mack = 0; mwrap = 0;
      mptr = 0; m_busy = 0; m_done = 0;
      return;
    end
    mack = 0;
    mwrap = 0;
    if (m_done) begin
      m_done = 0; m_busy = 0; mgrant = 0;
    end else if (m_busy) begin
      if (m_load) begin
        mq = m_val; m_done = 1; mack = mgrant;
      end else if (!pause) begin
        if (m_left > 0) begin
          mq = (mq + 1) % MODV;
          mwrap = (mq == 0);
          m_left--;
        end
        if (m_left == 0) begin
          m_done = 1; mack = mgrant;
        end
      end
    end else if (req0 || req1) begin
      w = (req0 && req1) ? mptr : (req1 ? 1 : 0);
      mgrant = 1 << w;
      mptr = 1 - w;
      m_load = !(w ? op1 : op0);
      m_val = w ? int'(data1) : int'(data0);
      m_left = m_val;
      m_busy = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_q", Q, mq);
    chk("model_grant", grant, mgrant);
    chk("model_ack", ack, mack);
    chk("model_busy", busy, m_busy);
    chk("model_wrap", wrap, mwrap);
    chk("grant_onehot", ($countones(grant) <= 1), 1);
    chk("ack_in_grant", ((ack & ~grant) == 2'b00), 1);
  endtask

  task automatic idle_inputs();
    rst = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    data0 = '0; data1 = '0; pause = 0;
  endtask

  typedef struct {
    bit rst, r0, o0; int d0;
    bit r1, o1; int d1; bit p;
    int q, g, a, b, w;
  } vec_t;

  vec_t tbl[12];
  logic [1:0] order[$];
  logic [1:0] prev_g;
  bit pseq[6];

  initial begin
    tbl[0]  = '{1, 0,0,0, 0,0,0, 0,  0,0,0,0,0};
    tbl[1]  = '{0, 1,0,5, 0,0,0, 0,  0,1,0,1,0};
    tbl[2]  = '{0, 0,0,0, 0,0,0, 0,  5,1,1,1,0};
    tbl[3]  = '{0, 0,0,0, 0,0,0, 0,  5,0,0,0,0};
    tbl[4]  = '{0, 1,0,6, 0,0,0, 0,  5,1,0,1,0};
    tbl[5]  = '{0, 0,0,0, 0,0,0, 0,  6,1,1,1,0};
    tbl[6]  = '{0, 0,0,0, 0,0,0, 0,  6,0,0,0,0};
    tbl[7]  = '{0, 0,0,0, 1,1,3, 0,  6,2,0,1,0};
    tbl[8]  = '{0, 0,0,0, 0,0,0, 0,  7,2,0,1,0};
    tbl[9]  = '{0, 0,0,0, 0,0,0, 0,  0,2,0,1,1};
    tbl[10] = '{0, 0,0,0, 0,0,0, 0,  1,2,2,1,0};
    tbl[11] = '{0, 0,0,0, 0,0,0, 0,  1,0,0,0,0};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; pause = tbl[i].p;
      req0 = tbl[i].r0; op0 = tbl[i].o0; data0 = W'(tbl[i].d0);
      req1 = tbl[i].r1; op1 = tbl[i].o1; data1 = W'(tbl[i].d1);
      tick();
      chk("tbl_q", Q, tbl[i].q);
      chk("tbl_grant", grant, tbl[i].g);
      chk("tbl_ack", ack, tbl[i].a);
      chk("tbl_busy", busy, tbl[i].b);
      chk("tbl_wrap", wrap, tbl[i].w);
    end

    // Both requesters held from reset: alternating grants.
    idle_inputs(); rst = 1; tick();
    rst = 0; req0 = 1; req1 = 1; op0 = 1; op1 = 1;
    data0 = W'(1); data1 = W'(1);
    prev_g = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant != 2'b00 && prev_g == 2'b00) order.push_back(grant);
      prev_g = grant;
    end
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk("rr_order", order[i], (i % 2 == 0) ? 1 : 2);
    idle_inputs(); tick();

    // COUNT 4 with a two-cycle pause after the first step.
    rst = 1; tick(); idle_inputs();
    req0 = 1; op0 = 1; data0 = W'(4); tick();
    idle_inputs();
    pseq = '{0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      pause = pseq[i];
      tick();
      if (i < 5) chk("pause_noack", ack, 0);
    end
    chk("pause_q", Q, 4);
    chk("pause_ack", ack, 1);
    pause = 0; tick();

    // Reset in the second EXEC cycle of COUNT 5.
    rst = 1; tick(); idle_inputs();
    req0 = 1; op0 = 1; data0 = W'(5); tick();
    idle_inputs(); tick();
    chk("abort_pre_q", Q, 1);
    rst = 1; tick(); rst = 0;
    chk("abort_q", Q, 0);
    chk("abort_grant", grant, 0);
    chk("abort_ack", ack, 0);
    req0 = 1; req1 = 1; op0 = 0; op1 = 0;
    data0 = W'(2); data1 = W'(3); tick();
    chk("abort_ptr", grant, 1);
    idle_inputs(); tick();
    chk("abort_load", Q, 2);
    tick();

    // COUNT 0: one EXEC cycle, Q unchanged, ack issued.
    req1 = 1; op1 = 1; data1 = '0; tick();
    idle_inputs(); tick();
    chk("zero_q", Q, 2);
    chk("zero_ack", ack, 2);
    tick();
    chk("zero_busy", busy, 0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      req0 = ($urandom_range(2) != 0);
      req1 = ($urandom_range(2) != 0);
      op0 = $urandom_range(1);
      op1 = $urandom_range(1);
      data0 = W'($urandom_range(MODV - 1));
      data1 = W'($urandom_range(MODV - 1));
      pause = ($urandom_range(3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
